alu: RTL and testbench

ALU -- requirements
Module: ALU

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_addsub.sv | 35 +++
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and data width for the 64-bit ALU.
// Imported by alu and alu_addsub.
package alu_pkg;

  localparam int ALU_W = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 64-bit ripple-carry adder/subtractor of full-adder cells.
// Subtract is a + ~b + 1; the final carry-out is never formed.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  output logic [ALU_W-1:0] sum,
  output logic             ovf
);

  logic [ALU_W-1:0] bx;
  logic [ALU_W-1:0] c;

  assign bx   = b ^ {ALU_W{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < ALU_W; i++) begin : g_fa
    assign sum[i] = a[i] ^ bx[i] ^ c[i];
    if (i < ALU_W - 1) begin : g_cy
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  // Signed overflow from operand and result sign bits.
  always_comb begin
    ovf = 1'b0;
    if (sub)
      ovf = (a[ALU_W-1] != b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
    else
      ovf = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
  end

endmodule

// File: rtl/alu.sv
// Registered 64-bit ALU: add, subtract, AND, XOR with overflow flag.
// Define ALU_CC_EN to add registered zero (ZF) and sign (SF) flags.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       S,
  input  logic [ALU_W-1:0] In1,
  input  logic [ALU_W-1:0] In2,
  output logic [ALU_W-1:0] OUTPUT,
  output logic             Overflow
`ifdef ALU_CC_EN
  ,
  output logic             ZF,
  output logic             SF
`endif
);

  logic [ALU_W-1:0] sum;
  logic             ov;
  logic [ALU_W-1:0] res;
  logic             res_ov;

  alu_addsub u_addsub (
    .a   (In1),
    .b   (In2),
    .sub (S == ALU_SUB),
    .sum (sum),
    .ovf (ov)
  );

  // Select the result; an unknown opcode yields zero.
  always_comb begin
    res    = '0;
    res_ov = 1'b0;
    case (S)
      ALU_ADD, ALU_SUB: begin
        res    = sum;
        res_ov = ov;
      end
      ALU_AND: res = In1 & In2;
      ALU_XOR: res = In1 ^ In2;
      default: begin
        res    = '0;
        res_ov = 1'b0;
      end
    endcase
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OUTPUT   <= '0;
      Overflow <= 1'b0;
`ifdef ALU_CC_EN
      ZF       <= 1'b0;
      SF       <= 1'b0;
`endif
    end else begin
      OUTPUT   <= res;
      Overflow <= res_ov;
`ifdef ALU_CC_EN
      ZF       <= (res == '0);
      SF       <= res[ALU_W-1];
`endif
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
// Condition-code checks are compiled in with ALU_CC_EN.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [1:0]  S;
  logic [63:0] In1;
  logic [63:0] In2;
  logic [63:0] OUTPUT;
  logic        Overflow;
`ifdef ALU_CC_EN
  logic        ZF;
  logic        SF;
`endif

  int tests;
  int fails;

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .S        (S),
    .In1      (In1),
    .In2      (In2),
    .OUTPUT   (OUTPUT),
    .Overflow (Overflow)
`ifdef ALU_CC_EN
    ,
    .ZF       (ZF),
    .SF       (SF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b, input string tag,
                      input logic [63:0] er, input logic eo,
                      input logic ez, input logic es);
    @(negedge clk);
    S   = op;
    In1 = a;
    In2 = b;
    @(posedge clk);
    #1;
    chk({tag, ".out"}, OUTPUT, er);
    chk({tag, ".ovf"}, {63'd0, Overflow}, {63'd0, eo});
`ifdef ALU_CC_EN
    chk({tag, ".zf"}, {63'd0, ZF}, {63'd0, ez});
    chk({tag, ".sf"}, {63'd0, SF}, {63'd0, es});
`else
    if (ez && es) tests = tests + 0;
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    S     = 2'b00;
    In1   = 64'd7;
    In2   = 64'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", OUTPUT, 64'd0);
    chk("rst.ovf", {63'd0, Overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    step(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_ovf",
         64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    step(2'b01, 64'h8000_0000_0000_0000, 64'd1, "sub_ovf",
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(2'b01, 64'd5, 64'd5, "sub_zero",
         64'd0, 1'b0, 1'b1, 1'b0);
    step(2'b10, 64'hF0F0, 64'hFF00, "and",
         64'hF000, 1'b0, 1'b0, 1'b0);
    step(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF, "xor",
         64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b1);
    step(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "add_neg",
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
    step(2'b01, 64'd0, 64'h8000_0000_0000_0000, "sub_min",
         64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    step(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "add_min",
         64'd0, 1'b1, 1'b1, 1'b0);
    step(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "and_nov",
         64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    step(2'b01, 64'd3, 64'd5, "sub_neg",
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
    step(2'b00, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, "add_mix",
         64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);
    step(2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, "xor_zero",
         64'd0, 1'b0, 1'b1, 1'b0);
    step(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "pre_rst",
         64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);

    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid.out", OUTPUT, 64'd0);
    chk("rst_mid.ovf", {63'd0, Overflow}, 64'd0);
`ifdef ALU_CC_EN
    chk("rst_mid.sf", {63'd0, SF}, 64'd0);
`endif
    @(posedge clk);
    #1;
    chk("rst_hold.out", OUTPUT, 64'd0);
    chk("rst_hold.ovf", {63'd0, Overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rel.out", OUTPUT, 64'h8000_0000_0000_0000);
    chk("rst_rel.ovf", {63'd0, Overflow}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
